egress_collector: RTL and testbench

//   Drains the four output FIFOs of the routing fabric (FIFO4..FIFO7) onto one
//   10-bit valid/ready stream tagged with the source port. Round-robin

---
 rtl/egress_collector.sv | 172 +++++++++++++++++
 tb/tb_egress_collector.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_collector.sv
// egress_collector: drains fabric FIFO4..FIFO7 onto one tagged valid/ready
// stream with round-robin arbitration and per-port saturating word counters.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   fifo4_out..fifo7_out  FIFO read data, valid the cycle after its pop
//   fifo_empty[3:0]       empty flags, bit0=FIFO4 .. bit3=FIFO7
//   enable                allow new grants (a word in progress always completes)
//   pop4..pop7            one-cycle pop strobes
//   out_data/out_port     collected word and its source port (0=FIFO4)
//   out_valid/out_ready   output handshake
//   cnt_clear             clear all word counters (beats a same-cycle increment)
//   cnt_sel/cnt_value     combinational read of one word counter
module egress_collector #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] fifo4_out,
    input  logic [DATA_W-1:0] fifo5_out,
    input  logic [DATA_W-1:0] fifo6_out,
    input  logic [DATA_W-1:0] fifo7_out,
    input  logic [3:0]        fifo_empty,
    input  logic              enable,
    output logic              pop4,
    output logic              pop5,
    output logic              pop6,
    output logic              pop7,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_port,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cnt_clear,
    input  logic [1:0]        cnt_sel,
    output logic [CNT_W-1:0]  cnt_value
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_SEND
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_grant;
    logic [1:0]        r_rr;
    logic [1:0]        r_port;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt [4];

    logic [1:0]        w_start;
    logic [1:0]        w_pick;
    logic              w_any;
    logic              w_hs;
    logic              w_take;
    logic [DATA_W-1:0] w_fifo_data;

    assign w_any = ~&fifo_empty;
    assign w_hs  = (r_state == S_SEND) && out_ready;

    // On a handshake rr is only updated at the edge, so the search for the
    // next grant made in the same cycle starts from grant+1 directly.
    assign w_start = (r_state == S_SEND) ? r_grant + 2'd1 : r_rr;

    // Descending scan so the smallest offset from w_start wins.
    always_comb begin
        w_pick = w_start;
        for (int k = 3; k >= 0; k--) begin
            if (!fifo_empty[w_start + 2'(k)]) begin
                w_pick = w_start + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable && w_any) begin
                    w_next = S_POP;
                    w_take = 1'b1;
                end
            end
            S_POP:  w_next = S_WAIT;
            S_WAIT: w_next = S_SEND;
            S_SEND: begin
                if (out_ready) begin
                    if (enable && w_any) begin
                        w_next = S_POP;
                        w_take = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_fifo_data = fifo4_out;
        unique case (r_grant)
            2'd0: w_fifo_data = fifo4_out;
            2'd1: w_fifo_data = fifo5_out;
            2'd2: w_fifo_data = fifo6_out;
            2'd3: w_fifo_data = fifo7_out;
            default: w_fifo_data = fifo4_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant <= 2'd0;
            r_rr    <= 2'd0;
            r_port  <= 2'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_take) begin
                r_grant <= w_pick;
            end
            if (r_state == S_WAIT) begin
                r_data  <= w_fifo_data;
                r_port  <= r_grant;
                r_valid <= 1'b1;
            end
            if (w_hs) begin
                r_valid <= 1'b0;
                r_rr    <= r_grant + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cnt_clear) begin
                    r_cnt[i] <= '0;
                end else if (w_hs && r_grant == 2'(i) && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign pop4      = (r_state == S_POP) && (r_grant == 2'd0);
    assign pop5      = (r_state == S_POP) && (r_grant == 2'd1);
    assign pop6      = (r_state == S_POP) && (r_grant == 2'd2);
    assign pop7      = (r_state == S_POP) && (r_grant == 2'd3);
    assign out_data  = r_data;
    assign out_port  = r_port;
    assign out_valid = r_valid;
    assign cnt_value = r_cnt[cnt_sel];

endmodule

// File: tb/tb_egress_collector.sv
// tb_egress_collector: randomized self-checking bench for egress_collector.
// FIFOs are modelled as arrays; expected order comes from a round-robin model.
module tb_egress_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] f_out [4];
    logic [3:0] fifo_empty;
    logic       enable;
    logic       pop4, pop5, pop6, pop7;
    logic [9:0] out_data;
    logic [1:0] out_port;
    logic       out_valid;
    logic       out_ready;
    logic       cnt_clear;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_value;
    logic [3:0] pops;

    always #5 clk = ~clk;

    egress_collector #(.DATA_W(10), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .fifo4_out(f_out[0]), .fifo5_out(f_out[1]),
        .fifo6_out(f_out[2]), .fifo7_out(f_out[3]),
        .fifo_empty(fifo_empty), .enable(enable),
        .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
        .out_data(out_data), .out_port(out_port),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clear(cnt_clear), .cnt_sel(cnt_sel), .cnt_value(cnt_value)
    );

    assign pops = {pop7, pop6, pop5, pop4};

    // Fabric FIFO model
    logic [9:0] mem [4][1024];
    int         wr_ptr [4];
    int         rd_ptr [4];

    assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
    assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);
    assign fifo_empty[2] = (wr_ptr[2] == rd_ptr[2]);
    assign fifo_empty[3] = (wr_ptr[3] == rd_ptr[3]);

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset) begin
                rd_ptr[i] <= wr_ptr[i];
            end else if (pops[i] && rd_ptr[i] != wr_ptr[i]) begin
                f_out[i]  <= mem[i][rd_ptr[i] % 1024];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    // Handshake collector and protocol monitor
    logic [1:0] got_port [$];
    logic [9:0] got_data [$];
    int         mon_err = 0;

    always @(posedge clk) begin
        if (reset) begin
            if ($countones(pops) > 1 || (pops & fifo_empty) != 4'd0) begin
                mon_err <= mon_err + 1;
            end
            if (out_valid && out_ready) begin
                got_port.push_back(out_port);
                got_data.push_back(out_data);
            end
        end
    end

    // Reference model: pending words per port, rr pointer, counters
    logic [9:0] exp_q [4][$];
    int         m_rr;
    int         m_cnt [4];
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic push(input int p, input logic [9:0] v);
        mem[p][wr_ptr[p] % 1024] = v;
        wr_ptr[p] = wr_ptr[p] + 1;
        exp_q[p].push_back(v);
    endtask

    task automatic model_next(output bit have, output int g,
                              output logic [9:0] d);
        have = 1'b0;
        g    = 0;
        d    = '0;
        for (int k = 0; k < 4; k++) begin
            if (!have && exp_q[(m_rr + k) % 4].size() > 0) begin
                have = 1'b1;
                g    = (m_rr + k) % 4;
            end
        end
        if (have) begin
            d    = exp_q[g].pop_front();
            m_rr = (g + 1) % 4;
            if (m_cnt[g] < 255) m_cnt[g] = m_cnt[g] + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            m_cnt[i] = 0;
        end
        m_rr = 0;
        got_port.delete();
        got_data.delete();
    endtask

    task automatic wait_hs(input int n, input int budget, output bit ok);
        int c = 0;
        while (got_port.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (got_port.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (pops !== 4'd0 || out_valid !== 1'b0) begin
            $display("FAIL reset_outputs pops=%b valid=%b want 0000/0",
                     pops, out_valid);
        end else n_pass++;
        n_chk++;
        if (out_data !== 10'd0 || out_port !== 2'd0) begin
            $display("FAIL reset_data data=%h port=%0d want 0/0",
                     out_data, out_port);
        end else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            n_chk++;
            if (cnt_value !== 8'd0) begin
                $display("FAIL reset_cnt%0d got=%0d want 0", i, cnt_value);
            end else n_pass++;
        end
        reset = 1'b1;
        m_rr = 0;
    endtask

    task automatic test_single();
        bit ok;
        bit have;
        int g;
        logic [9:0] d;
        int c = 0;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        push(2, 10'h2A5);
        while (pops == 4'd0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_chk++;
        if (pops !== 4'b0100) begin
            $display("FAIL single_pop pops=%b want 0100", pops);
        end else n_pass++;
        @(negedge clk);
        n_chk++;
        if (pops !== 4'd0 || out_valid !== 1'b0) begin
            $display("FAIL single_wait pops=%b valid=%b want 0000/0",
                     pops, out_valid);
        end else n_pass++;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 10'h2A5 || out_port !== 2'd2) begin
            $display("FAIL single_out v=%b d=%h p=%0d want 1/2a5/2",
                     out_valid, out_data, out_port);
        end else n_pass++;
        wait_hs(1, 10, ok);
        model_next(have, g, d);
        got_port.delete();
        got_data.delete();
        cnt_sel = 2'd2;
        #1;
        n_chk++;
        if (!ok || cnt_value !== 8'(m_cnt[2])) begin
            $display("FAIL single_cnt ok=%0d got=%0d want %0d",
                     ok, cnt_value, m_cnt[2]);
        end else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        bit have;
        int g;
        logic [9:0] d;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < 4; p++) begin
                push(p, 10'($urandom));
            end
        end
        wait_hs(12, 100, ok);
        n_chk++;
        if (!ok) $display("FAIL rr_timeout got=%0d want 12", got_port.size());
        else n_pass++;
        for (int k = 0; k < 12 && got_port.size() > 0; k++) begin
            model_next(have, g, d);
            n_chk++;
            if (!have || got_port[0] !== 2'(g) || got_data[0] !== d
                || got_port[0] !== 2'(k % 4)) begin
                $display("FAIL rr_word%0d port=%0d data=%h want %0d/%h",
                         k, got_port[0], got_data[0], k % 4, d);
            end else n_pass++;
            void'(got_port.pop_front());
            void'(got_data.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            n_chk++;
            if (cnt_value !== 8'd3) begin
                $display("FAIL rr_cnt%0d got=%0d want 3", i, cnt_value);
            end else n_pass++;
        end
        n_chk++;
        if (mon_err !== 0) $display("FAIL rr_pops violations=%0d want 0", mon_err);
        else n_pass++;
    endtask

    task automatic test_stall(input bit clr);
        bit have;
        int g;
        logic [9:0] d;
        logic [9:0] d0;
        int c = 0;
        bit ok = 1'b1;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        push(1, 10'($urandom));
        while (out_valid !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        d0 = out_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== d0 || pops !== 4'd0) ok = 1'b0;
        end
        n_chk++;
        if (!ok) $display("FAIL stall_hold v=%b d=%h pops=%b want 1/%h/0000",
                          out_valid, out_data, pops, d0);
        else n_pass++;
        cnt_sel = 2'd1;
        #1;
        n_chk++;
        if (cnt_value !== 8'd0) $display("FAIL stall_cnt got=%0d want 0", cnt_value);
        else n_pass++;
        out_ready = 1'b1;
        cnt_clear = clr;
        @(negedge clk);
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        model_next(have, g, d);
        if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        n_chk++;
        if (got_port.size() != 1 || got_data[0] !== d || got_port[0] !== 2'(g)) begin
            $display("FAIL stall_hs n=%0d want 1 word %h", got_port.size(), d);
        end else n_pass++;
        #1;
        n_chk++;
        if (cnt_value !== 8'(m_cnt[1]) || out_valid !== 1'b0) begin
            $display("FAIL stall_after cnt=%0d v=%b want %0d/0",
                     cnt_value, out_valid, m_cnt[1]);
        end else n_pass++;
        got_port.delete();
        got_data.delete();
    endtask

    task automatic test_saturation();
        bit ok;
        bit have;
        int g;
        logic [9:0] d;
        int bad = 0;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 260; k++) push(0, 10'($urandom));
        wait_hs(260, 900, ok);
        n_chk++;
        if (!ok) $display("FAIL sat_timeout got=%0d want 260", got_port.size());
        else n_pass++;
        while (got_port.size() > 0) begin
            model_next(have, g, d);
            if (!have || got_port[0] !== 2'(g) || got_data[0] !== d) bad++;
            void'(got_port.pop_front());
            void'(got_data.pop_front());
        end
        n_chk++;
        if (bad != 0) $display("FAIL sat_words bad=%0d want 0", bad);
        else n_pass++;
        cnt_sel = 2'd0;
        #1;
        n_chk++;
        if (cnt_value !== 8'(m_cnt[0]) || m_cnt[0] != 255) begin
            $display("FAIL sat_cnt got=%0d want 255", cnt_value);
        end else n_pass++;
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        #1;
        n_chk++;
        if (cnt_value !== 8'd0) $display("FAIL sat_clear got=%0d want 0", cnt_value);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        bit have;
        int g;
        logic [9:0] d;
        int c = 0;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        push(3, 10'($urandom));
        wait_hs(1, 20, ok);
        model_next(have, g, d);
        n_chk++;
        if (!ok || got_port[0] !== 2'd3 || got_data[0] !== d) begin
            $display("FAIL rwait_first ok=%0d want port 3 data %h", ok, d);
        end else n_pass++;
        got_port.delete();
        got_data.delete();
        push(3, 10'($urandom));
        while (pop7 !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cnt_sel = 2'd3;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || cnt_value !== 8'd0 || pops !== 4'd0) begin
            $display("FAIL rwait_reset v=%b cnt=%0d pops=%b want 0/0/0000",
                     out_valid, cnt_value, pops);
        end else n_pass++;
        @(negedge clk);
        n_chk++;
        if (pops !== 4'd0 || out_valid !== 1'b0) begin
            $display("FAIL rwait_after pops=%b v=%b want 0000/0", pops, out_valid);
        end else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        bit have;
        int g;
        logic [9:0] d;
        int total = 0;
        int c = 0;
        int bad = 0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            int n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) push(p, 10'($urandom));
            total += n;
        end
        while (got_port.size() < total && c < 3000) begin
            enable = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            c++;
        end
        enable = 1'b0;
        out_ready = 1'b0;
        ok = (got_port.size() == total);
        n_chk++;
        if (!ok) $display("FAIL rand_count got=%0d want %0d", got_port.size(), total);
        else n_pass++;
        while (got_port.size() > 0) begin
            model_next(have, g, d);
            if (!have || got_port[0] !== 2'(g) || got_data[0] !== d) bad++;
            void'(got_port.pop_front());
            void'(got_data.pop_front());
        end
        n_chk++;
        if (bad != 0) $display("FAIL rand_order bad=%0d want 0", bad);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            n_chk++;
            if (cnt_value !== 8'(m_cnt[i])) begin
                $display("FAIL rand_cnt%0d got=%0d want %0d", i, cnt_value, m_cnt[i]);
            end else n_pass++;
        end
        n_chk++;
        if (mon_err !== 0) $display("FAIL rand_pops violations=%0d want 0", mon_err);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        cnt_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            wr_ptr[i] = 0;
            m_cnt[i] = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_stall(1'b0);
        test_stall(1'b1);
        test_saturation();
        test_reset_in_wait();
        for (int r = 0; r < 4; r++) test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
